// File: rtl/ws_column_sequencer_pkg.sv
// ws_pkg: shared types and helpers for the weight-stationary column sequencer.
//   WS_DATA_W  - default word width for filter, ifmap and psum words
//   ws_state_e - sequencer FSM states
//   lane_lsb   - bit offset of lane k in a packed vector of w-bit words
package ws_pkg;

    localparam int WS_DATA_W = 16;

    typedef enum logic [1:0] {IDLE, LOAD_F, RUN, DRAIN} ws_state_e;

    function automatic int lane_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/ws_column_sequencer_skew_line.sv
// ws_skew_line: per-lane skew delay of DEPTH registers followed by the PE-facing output register.
//   clk  - clock
//   rst  - synchronous active-low reset, clears every stage
//   din  - lane word entering the line
//   dout - lane word after DEPTH+1 clocks (registered)
module ws_skew_line #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    // sr[DEPTH] is the output register; sr[0..DEPTH-1] are the skew stages
    logic [DATA_W-1:0] sr [0:DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i <= DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i <= DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH];

endmodule

// File: rtl/ws_column_sequencer.sv
// ws_column_sequencer: drives one weight-stationary PE column (filter load, skewed ifmap stream, psum collect).
//   clk, rst              - clock, synchronous active-low reset
//   filt_valid/ready/data - filter vector stream, weight for PE k in lane k
//   ifm_valid/ready/data  - ifmap vector stream, ifm_last closes a pass
//   psum_valid/data       - one column result per accepted ifmap vector, no backpressure
//   complete              - one-cycle pulse once a pass has fully drained
//   pe_filt, pe_load_f    - filter shift chain into PE0
//   pe_load_i, pe_start   - broadcast compute enables
//   pe_ifmap              - skewed ifmap lanes, lane k to PE k
//   pe_psum0              - psum input of PE0, tied to zero
//   pe_psum_last          - psum output of the last PE
module ws_column_sequencer
    import ws_pkg::*;
#(
    parameter int DATA_W = WS_DATA_W,
    parameter int NUM_PE = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     filt_valid,
    output logic                     filt_ready,
    input  logic [NUM_PE*DATA_W-1:0] filt_data,
    input  logic                     ifm_valid,
    output logic                     ifm_ready,
    input  logic [NUM_PE*DATA_W-1:0] ifm_data,
    input  logic                     ifm_last,
    output logic                     psum_valid,
    output logic [DATA_W-1:0]        psum_data,
    output logic                     complete,
    output logic [DATA_W-1:0]        pe_filt,
    output logic                     pe_load_f,
    output logic                     pe_load_i,
    output logic                     pe_start,
    output logic [NUM_PE*DATA_W-1:0] pe_ifmap,
    output logic [DATA_W-1:0]        pe_psum0,
    input  logic [DATA_W-1:0]        pe_psum_last
);

    localparam int VW = NUM_PE * DATA_W;
    localparam int CW = $clog2(NUM_PE);

    ws_state_e         state;
    logic [VW-1:0]     filt_buf;
    logic [CW-1:0]     cnt;
    logic              filt_loaded;
    logic [VW-1:0]     in_vec;
    logic              in_vld;
    logic [NUM_PE:0]   tag;
    logic              filt_fire;
    logic              ifm_fire;
    logic              drain_empty;

    assign filt_fire   = filt_valid & filt_ready;
    // a filter handshake in the same cycle takes priority, so the ifmap is not consumed
    assign ifm_fire    = ifm_valid & ifm_ready & ~filt_fire;
    assign drain_empty = ~in_vld & ~|tag;
    assign pe_psum0    = '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            filt_buf    <= '0;
            cnt         <= '0;
            filt_loaded <= 1'b0;
            filt_ready  <= 1'b0;
            ifm_ready   <= 1'b0;
            complete    <= 1'b0;
            pe_filt     <= '0;
            pe_load_f   <= 1'b0;
            pe_load_i   <= 1'b0;
            pe_start    <= 1'b0;
        end else begin
            complete <= 1'b0;
            case (state)
                IDLE: begin
                    filt_ready <= 1'b1;
                    ifm_ready  <= filt_loaded;
                    if (filt_fire) begin
                        // the deepest PE's weight goes first so the chain settles in lane order
                        state      <= LOAD_F;
                        filt_ready <= 1'b0;
                        ifm_ready  <= 1'b0;
                        pe_load_f  <= 1'b1;
                        pe_filt    <= filt_data[lane_lsb(NUM_PE-1, DATA_W) +: DATA_W];
                        filt_buf   <= filt_data << DATA_W;
                        cnt        <= CW'(NUM_PE-1);
                    end else if (ifm_fire) begin
                        state      <= ifm_last ? DRAIN : RUN;
                        filt_ready <= 1'b0;
                        ifm_ready  <= ~ifm_last;
                        pe_load_i  <= 1'b1;
                        pe_start   <= 1'b1;
                    end
                end
                LOAD_F: begin
                    if (cnt == '0) begin
                        state       <= IDLE;
                        pe_load_f   <= 1'b0;
                        pe_filt     <= '0;
                        filt_loaded <= 1'b1;
                        filt_ready  <= 1'b1;
                        ifm_ready   <= 1'b1;
                    end else begin
                        cnt      <= cnt - 1'b1;
                        pe_filt  <= filt_buf[VW-1 -: DATA_W];
                        filt_buf <= filt_buf << DATA_W;
                    end
                end
                RUN: begin
                    if (ifm_fire && ifm_last) begin
                        state     <= DRAIN;
                        ifm_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    // load_i/start stay high until the last real slot has left the column
                    if (drain_empty) begin
                        state      <= IDLE;
                        complete   <= 1'b1;
                        pe_load_i  <= 1'b0;
                        pe_start   <= 1'b0;
                        filt_ready <= 1'b1;
                        ifm_ready  <= filt_loaded;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // bubbles are zero vectors so the PEs keep accumulating without being cleared
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_vec     <= '0;
            in_vld     <= 1'b0;
            tag        <= '0;
            psum_valid <= 1'b0;
            psum_data  <= '0;
        end else begin
            in_vec     <= ifm_fire ? ifm_data : '0;
            in_vld     <= ifm_fire;
            tag        <= {tag[NUM_PE-1:0], in_vld};
            psum_valid <= tag[NUM_PE];
            psum_data  <= tag[NUM_PE] ? pe_psum_last : '0;
        end
    end

    for (genvar k = 0; k < NUM_PE; k++) begin : g_lane
        ws_skew_line #(
            .DATA_W(DATA_W),
            .DEPTH (k)
        ) u_skew (
            .clk (clk),
            .rst (rst),
            .din (in_vec[lane_lsb(k, DATA_W) +: DATA_W]),
            .dout(pe_ifmap[lane_lsb(k, DATA_W) +: DATA_W])
        );
    end

endmodule

// File: doc/ws_column_sequencer.md
Name: ws_column_sequencer

Overview:
- Initiator for one weight-stationary PE column of NUM_PE chained PEs.
- Loads the column's filter weights by shifting them through the PE filter chain.
- Streams ifmap vectors into the column with per-lane skew, drives the handshake controls (load_f, load_i, start), and collects accumulated psums from the last PE.
- Sits between the buffer/DMA side (valid/ready streams) and the PE array.

Parameters:
- DATA_W, 16, width of filter, ifmap and psum words.
- NUM_PE, 4, PEs in the column (≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- filt_valid  in  1  filter vector available.
- filt_ready  out  1  filter vector accepted when valid&ready.
- filt_data  in  NUM_PE*DATA_W  weight for PE k at bits [k*DATA_W +: DATA_W].
- ifm_valid  in  1  ifmap vector available.
- ifm_ready  out  1  ifmap vector accepted.
- ifm_data  in  NUM_PE*DATA_W  ifmap word for lane k.
- ifm_last  in  1  marks the final vector of a pass.
- psum_valid  out  1  psum_data valid; consumer must always accept (no backpressure).
- psum_data  out  DATA_W  column result.
- complete  out  1  one-cycle pulse when a pass has fully drained.
- pe_filt  out  DATA_W  to in_filt of PE0.
- pe_load_f  out  1  broadcast load_f.
- pe_load_i  out  1  broadcast load_i.
- pe_start  out  1  broadcast start.
- pe_ifmap  out  NUM_PE*DATA_W  lane k to in_ifmap of PE k.
- pe_psum0  out  DATA_W  to in_psum of PE0; constant 0.
- pe_psum_last  in  DATA_W  out_psum of PE NUM_PE-1.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State IDLE; all outputs 0; skew and valid-tag registers cleared; filt_loaded cleared.
  - Reset mid-operation aborts the pass; no psum_valid and no complete are produced for it.
- All outputs are registered.
- FSM states: IDLE, LOAD_F, RUN, DRAIN.
- IDLE:
  - filt_ready=1.
  - On filt accept, latch the vector → LOAD_F.
  - ifm_ready=filt_loaded. An ifmap accept → RUN. If filters are not yet loaded, ifmap is never accepted.
  - If filt_valid and ifm_valid are both high, the filter wins.
- LOAD_F:
  - NUM_PE cycles with pe_load_f=1 and pe_load_i=pe_start=0.
  - pe_filt presents the word for PE NUM_PE-1 first, down to PE0 last, so that after NUM_PE shifts PE k holds weight k.
  - Then set filt_loaded → IDLE.
- RUN:
  - pe_load_i=pe_start=1 continuously.
  - ifm_ready=1 each cycle.
  - Accepted vector: lane k passes through k skew registers before pe_ifmap[k].
  - A cycle with no accept injects a zero vector (bubble) so PE contents are never cleared, because the PE zeroes psum whenever load_i&start drops.
  - A NUM_PE+1-deep valid-tag shift register tracks real vs bubble slots.
  - Accepting ifm_last → DRAIN.
  - filt_valid is ignored in RUN.
- DRAIN:
  - ifm_ready=0; bubbles keep being injected with load_i=start=1.
  - When the valid-tag register is empty: complete=1 for one cycle, drop load_i/start → IDLE.
  - filt_loaded stays set, so weights are reused for the next pass.
- Latency: a vector accepted at edge t produces psum_valid=1 with its result after edge t+NUM_PE+2, i.e. 6 cycles for NUM_PE=4.
- Results emerge in acceptance order, one per accepted vector; bubbles never raise psum_valid.
- complete asserts the cycle after the last psum_valid.
- Arithmetic: psum = Σ_k filt_k·ifm_k, each product and sum truncated modulo 2^DATA_W, matching PE wrap behaviour.
- pe_psum0 is held at 0.

Decomposition:
- Shared package ws_pkg holds:
  - DATA_W default.
  - State enum {IDLE, LOAD_F, RUN, DRAIN}.
  - Lane slice helper function.
- One natural sub-module: ws_skew_line, a parameterised per-lane delay line of depth k, instantiated NUM_PE times via generate.

Test Plan:
- Filter load: filt_data={4,3,2,1} (PE3..PE0).
  - pe_load_f high exactly 4 cycles; pe_filt sequence 4,3,2,1.
  - ifm_ready rises afterwards.
- Single vector with ifm_last, ifm {1,1,1,1}, weights {1,2,3,4}:
  - psum_valid once with psum_data=10, 6 cycles after accept.
  - complete pulses on the next cycle.
- Back-to-back 3 vectors {1,1,1,1},{2,2,2,2},{0,0,0,5}:
  - psum_data 10, 20, 20 on consecutive cycles.
- Gapped input: ifm_valid low 2 cycles between two vectors:
  - results keep the 2-cycle gap, psum_valid low during the gap, values correct.
- Wrap: weights all 0x8000, ifm all 3:
  - psum_data = 0x0000 (per-product truncation 0x8000, sum of four mod 2^16 = 0).
- Reset mid-RUN after 2 accepts:
  - no psum_valid and no complete; after release, ifm_ready=0 until a new filter is loaded.
